// File: rtl/gemm_pkg.sv
// Shared GEMM types and default widths for the systolic-array processing elements.
package gemm_pkg;

    typedef enum logic {
        PE_OS = 1'b0,
        PE_WS = 1'b1
    } pe_mode_e;

    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 32;

endpackage

// File: rtl/pe_mac_sat.sv
// Signed multiply-add: full-width product, sign-extended, added to an accumulator-width addend.
// Build with PE_SAT_EN defined to clamp the sum to the signed range and flag the clamp.
module pe_mac_sat
    import gemm_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    input  logic signed [ACC_W-1:0]  addend,
    output logic signed [ACC_W-1:0]  sum,
    output logic                     sat
);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;

    assign prod     = (2*DATA_W)'(a) * (2*DATA_W)'(b);
    assign prod_ext = ACC_W'(prod);

`ifdef PE_SAT_EN
    logic signed [ACC_W:0] wide_sum;
    logic                  ovf;

    // One guard bit: the top two bits disagree exactly when the true sum left the range.
    assign wide_sum = (ACC_W+1)'(addend) + (ACC_W+1)'(prod_ext);
    assign ovf      = wide_sum[ACC_W] ^ wide_sum[ACC_W-1];

    always_comb begin
        sum = wide_sum[ACC_W-1:0];
        sat = 1'b0;
        if (ovf) begin
            sat = 1'b1;
            sum = wide_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
`else
    assign sum = addend + prod_ext;
    assign sat = 1'b0;
`endif

endmodule

// File: rtl/pe_mm.sv
// Systolic GEMM processing element: output-stationary or weight-stationary MAC with a result drain chain.
// Saturating arithmetic is enabled by defining PE_SAT_EN; otherwise sums wrap and sat_flag stays 0.
module pe_mm
    import gemm_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              mode,
    input  logic              clear_acc,
    input  logic              load_w,
    input  logic [DATA_W-1:0] a_in,
    output logic [DATA_W-1:0] a_out,
    input  logic [DATA_W-1:0] b_in,
    output logic [DATA_W-1:0] b_out,
    input  logic [ACC_W-1:0]  psum_in,
    output logic [ACC_W-1:0]  psum_out,
    input  logic              cap,
    input  logic              shift,
    input  logic [ACC_W-1:0]  drain_in,
    input  logic              drain_in_vld,
    output logic [ACC_W-1:0]  drain_out,
    output logic              drain_vld,
    output logic [ACC_W-1:0]  acc_out,
    output logic              drop_err,
    output logic              sat_flag
);

    pe_mode_e          mode_reg, mode_next;
    logic [DATA_W-1:0] a_reg, a_next;
    logic [DATA_W-1:0] b_reg, b_next;
    logic [DATA_W-1:0] w_reg, w_next;
    logic [ACC_W-1:0]  acc_reg, acc_next;
    logic [ACC_W-1:0]  psum_reg, psum_next;
    logic [ACC_W-1:0]  res_reg, res_next;
    logic              res_vld_reg, res_vld_next;
    logic              drop_err_reg, drop_err_next;
    logic              sat_reg, sat_next;

    logic signed [ACC_W-1:0] acc_base;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [ACC_W-1:0] psum_sum;
    logic                    acc_sat;
    logic                    psum_sat;

    // A clear in the same cycle as a MAC restarts the accumulation from this product.
    assign acc_base = clear_acc ? '0 : $signed(acc_reg);

    pe_mac_sat #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_acc_mac (
        .a      ($signed(a_in)),
        .b      ($signed(b_in)),
        .addend (acc_base),
        .sum    (acc_sum),
        .sat    (acc_sat)
    );

    pe_mac_sat #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_psum_mac (
        .a      ($signed(a_in)),
        .b      ($signed(w_reg)),
        .addend ($signed(psum_in)),
        .sum    (psum_sum),
        .sat    (psum_sat)
    );

    always_comb begin
        mode_next     = mode_reg;
        a_next        = a_reg;
        b_next        = b_reg;
        w_next        = w_reg;
        acc_next      = acc_reg;
        psum_next     = psum_reg;
        res_next      = res_reg;
        res_vld_next  = res_vld_reg;
        drop_err_next = drop_err_reg;
        sat_next      = sat_reg;

        if (clear_acc) begin
            mode_next = pe_mode_e'(mode);
            acc_next  = '0;
        end

        // Behaviour follows the latched mode; a new mode takes effect the cycle after clear_acc.
        if (mode_reg == PE_OS) begin
            if (en) begin
                a_next   = a_in;
                b_next   = b_in;
                acc_next = acc_sum;
                sat_next = sat_reg | acc_sat;
            end
        end else begin
            if (load_w) begin
                w_next = b_in;
                b_next = b_in;
            end else if (en) begin
                a_next    = a_in;
                psum_next = psum_sum;
                sat_next  = sat_reg | psum_sat;
            end
        end

        if (cap) begin
            res_next     = acc_next;
            res_vld_next = 1'b1;
            acc_next     = '0;
            if (shift && drain_in_vld) begin
                drop_err_next = 1'b1;
            end
        end else if (shift) begin
            res_next     = drain_in;
            res_vld_next = drain_in_vld;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_reg     <= PE_OS;
            a_reg        <= '0;
            b_reg        <= '0;
            w_reg        <= '0;
            acc_reg      <= '0;
            psum_reg     <= '0;
            res_reg      <= '0;
            res_vld_reg  <= 1'b0;
            drop_err_reg <= 1'b0;
            sat_reg      <= 1'b0;
        end else begin
            mode_reg     <= mode_next;
            a_reg        <= a_next;
            b_reg        <= b_next;
            w_reg        <= w_next;
            acc_reg      <= acc_next;
            psum_reg     <= psum_next;
            res_reg      <= res_next;
            res_vld_reg  <= res_vld_next;
            drop_err_reg <= drop_err_next;
            sat_reg      <= sat_next;
        end
    end

    assign a_out     = a_reg;
    assign b_out     = b_reg;
    assign psum_out  = psum_reg;
    assign drain_out = res_reg;
    assign drain_vld = res_vld_reg;
    assign acc_out   = acc_reg;
    assign drop_err  = drop_err_reg;
    assign sat_flag  = sat_reg;

endmodule
